// File: rtl/mm_pkg.sv
// mm_pkg: shared constants, types and helpers for the matrix-multiply engine.
//   DIM            matrix dimension (rows = cols)
//   MAT_SIZE       elements per matrix, DIM*DIM
//   IN_ELEMT_SIZE  signed A/B element width
//   OUT_ELEMT_SIZE signed C element width, >= 2*IN_ELEMT_SIZE + clog2(DIM)
package mm_pkg;

    localparam int unsigned DIM            = 8;
    localparam int unsigned MAT_SIZE       = 64;
    localparam int unsigned IN_ELEMT_SIZE  = 8;
    localparam int unsigned OUT_ELEMT_SIZE = 19;

    localparam int unsigned ADDR_W = $clog2(MAT_SIZE);
    localparam int unsigned IDX_W  = $clog2(DIM);

    typedef logic [ADDR_W-1:0]                addr_t;
    typedef logic [IDX_W-1:0]                 idx_t;
    typedef logic signed [IN_ELEMT_SIZE-1:0]  in_t;
    typedef logic signed [OUT_ELEMT_SIZE-1:0] out_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    localparam idx_t IDX_MAX = idx_t'(DIM - 1);

    // Row-major element address: (row, col) -> row*DIM + col.
    function automatic addr_t elem_addr(idx_t row, idx_t col);
        return addr_t'(row) * addr_t'(DIM) + addr_t'(col);
    endfunction

endpackage

// File: rtl/mm_if.sv
// mm_if: matrix-multiply test interface bundling load, compute and readback signals.
//   load_mem          load window
//   wenA/addrA/wdA    matrix A byte write
//   wenB/addrB/wdB    matrix B byte write
//   wenC/addrC        matrix C clear enable / read-clear address
//   start             compute request (level-sampled)
//   done              result ready
//   rdC               C read data (1-cycle latency)
// master: the driving side (bench); slave: the engine.
interface mm_if;
    import mm_pkg::*;

    logic  load_mem;
    logic  wenA;
    addr_t addrA;
    in_t   wdA;
    logic  wenB;
    addr_t addrB;
    in_t   wdB;
    logic  wenC;
    addr_t addrC;
    logic  start;
    logic  done;
    out_t  rdC;

    modport master (
        output load_mem, wenA, addrA, wdA, wenB, addrB, wdB, wenC, addrC, start,
        input  done, rdC
    );

    modport slave (
        input  load_mem, wenA, addrA, wdA, wenB, addrB, wdB, wenC, addrC, start,
        output done, rdC
    );

endinterface

// File: rtl/mm_mac.sv
// mm_mac: registered multiply-accumulate stage of the engine.
//   clk, reset       clock, asynchronous active-high reset
//   in_valid         issue stage holds a valid A/B address pair
//   in_first         issue is k==0 (restart accumulation)
//   in_last          issue is k==DIM-1 (result completes)
//   a, b             A/B read data for the issued addresses
//   res_valid        res is a finished dot product; C write happens this edge
//   res              accumulator next value (the value written to C)
module mm_mac
    import mm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_first,
    input  logic in_last,
    input  in_t  a,
    input  in_t  b,
    output logic res_valid,
    output out_t res
);

    localparam int unsigned PROD_W = 2 * IN_ELEMT_SIZE;

    logic valid_q;
    logic first_q;
    logic last_q;
    in_t  a_q;
    in_t  b_q;
    out_t acc_q;

    logic signed [PROD_W-1:0] prod;
    out_t                     prod_ext;
    out_t                     acc_next;

    always_comb begin
        prod     = a_q * b_q;
        prod_ext = {{(OUT_ELEMT_SIZE - PROD_W){prod[PROD_W-1]}}, prod};
        acc_next = (first_q ? '0 : acc_q) + prod_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= in_valid;
            first_q <= in_first;
            last_q  <= in_last;
            a_q     <= a;
            b_q     <= b;
            if (valid_q) begin
                acc_q <= acc_next;
            end
        end
    end

    // The C write uses the combinational sum so it lands on the same edge as the accumulate.
    assign res_valid = valid_q & last_q;
    assign res       = acc_next;

endmodule

// File: rtl/mm_engine.sv
// mm_engine: matrix-multiply responder. Loads A/B, computes C = A x B on start,
// raises done, and serves C for readback.
//   clk    clock, all logic on posedge
//   reset  asynchronous active-high reset
//   bus    mm_if slave: load/write/clear inputs, start, done and rdC outputs
module mm_engine
    import mm_pkg::*;
(
    input logic clk,
    input logic reset,
    mm_if.slave bus
);

    state_t state_q, state_d;

    idx_t  i_q, j_q, k_q;
    logic  issue_end_q;

    // Issue stage: registered addresses plus tags travelling with them.
    logic  iss_valid_q;
    logic  iss_first_q;
    logic  iss_last_q;
    logic  iss_final_q;
    addr_t iss_addr_a_q;
    addr_t iss_addr_b_q;
    addr_t iss_addr_c_q;

    // Tags aligned with the MAC's data register stage.
    addr_t p1_addr_c_q;
    logic  p1_final_q;
    logic  final_wr_q;

    out_t  rdc_q;

    in_t   mem_a [MAT_SIZE];
    in_t   mem_b [MAT_SIZE];
    out_t  mem_c [MAT_SIZE];

    logic  start_cmp;
    logic  issuing;
    logic  last_issue;
    logic  load_ok;
    logic  mac_valid;
    out_t  mac_res;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.load_mem) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (final_wr_q) state_d = DONE;
            end
            DONE: begin
                if (bus.load_mem)   state_d = IDLE;
                else if (bus.start) state_d = COMPUTE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_cmp  = (state_q != COMPUTE) && (state_d == COMPUTE);
        issuing    = (state_q == COMPUTE) && !issue_end_q;
        last_issue = issuing && (i_q == IDX_MAX) && (j_q == IDX_MAX) && (k_q == IDX_MAX);
        load_ok    = (state_q != COMPUTE) && bus.load_mem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- i/j/k counters (k innermost) ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            issue_end_q <= 1'b0;
        end else if (start_cmp) begin
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            issue_end_q <= 1'b0;
        end else if (issuing) begin
            if (last_issue) issue_end_q <= 1'b1;
            if (k_q == IDX_MAX) begin
                k_q <= '0;
                if (j_q == IDX_MAX) begin
                    j_q <= '0;
                    i_q <= i_q + idx_t'(1);
                end else begin
                    j_q <= j_q + idx_t'(1);
                end
            end else begin
                k_q <= k_q + idx_t'(1);
            end
        end
    end

    // ---------------- issue pipeline ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_q  <= 1'b0;
            iss_first_q  <= 1'b0;
            iss_last_q   <= 1'b0;
            iss_final_q  <= 1'b0;
            iss_addr_a_q <= '0;
            iss_addr_b_q <= '0;
            iss_addr_c_q <= '0;
            p1_addr_c_q  <= '0;
            p1_final_q   <= 1'b0;
            final_wr_q   <= 1'b0;
        end else begin
            iss_valid_q  <= issuing;
            iss_first_q  <= (k_q == '0);
            iss_last_q   <= (k_q == IDX_MAX);
            iss_final_q  <= last_issue;
            iss_addr_a_q <= elem_addr(i_q, k_q);
            iss_addr_b_q <= elem_addr(k_q, j_q);
            iss_addr_c_q <= elem_addr(i_q, j_q);
            p1_addr_c_q  <= iss_addr_c_q;
            p1_final_q   <= iss_valid_q && iss_final_q;
            // Set on the edge the last C element is written; FSM leaves COMPUTE one edge later.
            final_wr_q   <= p1_final_q;
        end
    end

    mm_mac u_mac (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iss_valid_q),
        .in_first  (iss_first_q),
        .in_last   (iss_last_q),
        .a         (mem_a[iss_addr_a_q]),
        .b         (mem_b[iss_addr_b_q]),
        .res_valid (mac_valid),
        .res       (mac_res)
    );

    // ---------------- memories (not reset) ----------------
    always_ff @(posedge clk) begin
        if (load_ok && bus.wenA) mem_a[bus.addrA] <= bus.wdA;
        if (load_ok && bus.wenB) mem_b[bus.addrB] <= bus.wdB;
        if (load_ok && bus.wenC) begin
            mem_c[bus.addrC] <= '0;
        end else if (mac_valid) begin
            mem_c[p1_addr_c_q] <= mac_res;
        end
    end

    // Readback: old value on a same-edge clear; held while computing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdc_q <= '0;
        end else if (state_q != COMPUTE) begin
            rdc_q <= mem_c[bus.addrC];
        end
    end

    assign bus.done = (state_q == DONE);
    assign bus.rdC  = rdc_q;

endmodule

// File: tb/tb_mm_engine.sv
// tb_mm_engine: directed/randomized bench for mm_engine with a plain-arithmetic
// matrix-product reference model.
module tb_mm_engine;
    import mm_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mm_if bus ();

    mm_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ma [MAT_SIZE];
    int mb [MAT_SIZE];
    int mc [MAT_SIZE];
    int n_total = 0;
    int n_pass  = 0;
    int rise;
    int old5;
    int pick;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic idle_inputs;
        bus.load_mem = 1'b0;
        bus.wenA = 1'b0; bus.addrA = '0; bus.wdA = '0;
        bus.wenB = 1'b0; bus.addrB = '0; bus.wdB = '0;
        bus.wenC = 1'b0; bus.addrC = '0;
        bus.start = 1'b0;
    endtask

    task automatic compute_model;
        for (int r = 0; r < int'(DIM); r++) begin
            for (int c = 0; c < int'(DIM); c++) begin
                int s = 0;
                for (int k = 0; k < int'(DIM); k++) s += ma[r*DIM+k] * mb[k*DIM+c];
                mc[r*DIM+c] = s;
            end
        end
    endtask

    task automatic load_ab;
        bus.load_mem = 1'b1;
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            bus.wenA = 1'b1; bus.addrA = addr_t'(n); bus.wdA = in_t'(ma[n]);
            bus.wenB = 1'b1; bus.addrB = addr_t'(n); bus.wdB = in_t'(mb[n]);
            tick();
        end
        idle_inputs();
    endtask

    // Edge 0 samples start; rise = first edge index at which done reads 1.
    // For the first 'inject' edges, garbage loads are driven with load_mem high.
    task automatic run_compute(input int inject, output int rise_edge);
        bus.load_mem = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rise_edge = -1;
        for (int e = 1; e <= 600; e++) begin
            if (e <= inject) begin
                bus.load_mem = 1'b1;
                bus.wenA = 1'b1; bus.addrA = addr_t'($urandom); bus.wdA = in_t'($urandom);
                bus.wenB = 1'b1; bus.addrB = addr_t'($urandom); bus.wdB = in_t'($urandom);
                bus.wenC = 1'b1; bus.addrC = addr_t'($urandom);
                bus.start = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            if (bus.done === 1'b1) begin
                rise_edge = e;
                break;
            end
        end
        idle_inputs();
    endtask

    task automatic sweep(input string tag);
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            bus.addrC = addr_t'(n);
            tick();
            check($sformatf("%s C[%0d]", tag, n), bus.rdC, mc[n]);
        end
    endtask

    task automatic fill_random;
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            ma[n] = int'($urandom_range(255)) - 128;
            mb[n] = int'($urandom_range(255)) - 128;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset done", bus.done, 0);
        check("reset rdC", bus.rdC, 0);
        reset = 1'b0;
        tick();

        // Identity A, B[n] = n-32.
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            ma[n] = ((n / int'(DIM)) == (n % int'(DIM))) ? 1 : 0;
            mb[n] = n - 32;
        end
        load_ab();
        compute_model();
        run_compute(0, rise);
        check("identity done edge", rise, 515);
        sweep("identity");
        check("done held after sweep", bus.done, 1);
        repeat (20) tick();
        check("done held idle", bus.done, 1);

        // Worst-case positive magnitude.
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            ma[n] = -128;
            mb[n] = -128;
        end
        load_ab();
        compute_model();
        run_compute(0, rise);
        check("neg128 done edge", rise, 515);
        sweep("neg128");

        // Worst-case negative.
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            ma[n] = 127;
            mb[n] = -128;
        end
        load_ab();
        compute_model();
        run_compute(0, rise);
        check("mixed done edge", rise, 515);
        sweep("mixed");

        // Random data.
        fill_random();
        load_ab();
        compute_model();
        run_compute(0, rise);
        check("random done edge", rise, 515);
        sweep("random");

        // Clear C[5] from DONE; same-edge read returns old value.
        old5 = mc[5];
        bus.load_mem = 1'b1;
        bus.wenC = 1'b1;
        bus.addrC = addr_t'(5);
        tick();
        check("clear same-edge read", bus.rdC, old5);
        check("load clears done", bus.done, 0);
        bus.wenC = 1'b0;
        bus.load_mem = 1'b0;
        tick();
        check("C[5] cleared", bus.rdC, 0);
        mc[5] = 0;
        sweep("after clear");

        // Writes during compute are ignored; result uses the loaded A/B.
        compute_model();
        run_compute(40, rise);
        check("inject done edge", rise, 515);
        sweep("inject");
        run_compute(0, rise);
        check("rerun done edge", rise, 515);
        sweep("rerun");

        // start held high with load_mem high: no compute.
        fill_random();
        bus.start = 1'b1;
        bus.load_mem = 1'b1;
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            bus.wenA = 1'b1; bus.addrA = addr_t'(n); bus.wdA = in_t'(ma[n]);
            bus.wenB = 1'b1; bus.addrB = addr_t'(n); bus.wdB = in_t'(mb[n]);
            tick();
        end
        bus.wenA = 1'b0;
        bus.wenB = 1'b0;
        repeat (600) tick();
        check("no compute under load", bus.done, 0);
        compute_model();
        run_compute(0, rise);
        check("start after load drop", rise, 515);
        sweep("after load drop");

        // Reset 200 cycles into a compute, then rerun.
        pick = 0;
        for (int n = 0; n < int'(MAT_SIZE); n++) begin
            if (mc[n] != 0) pick = n;
        end
        bus.addrC = addr_t'(pick);
        tick();
        check("pre-reset rdC", bus.rdC, mc[pick]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (200) tick();
        check("mid compute done", bus.done, 0);
        reset = 1'b1;
        #1;
        check("async reset done", bus.done, 0);
        check("async reset rdC", bus.rdC, 0);
        tick();
        reset = 1'b0;
        tick();
        run_compute(0, rise);
        check("post-reset done edge", rise, 515);
        sweep("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
